plusminus_sched: RTL

Event scheduler and BCD up/down counter that consumes the three toggle-encoded event lines (`plus`, `minus`, `reset`) produced by the push-button one-shot stage. It converts each toggle into a request and latches the request as pending. It services one request per cycle with fixed priority and applies it to a two-digit BCD count, which the 7-segment display stage reads.

---
 rtl/plusminus_sched.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/plusminus_sched.sv
// Event scheduler and two-digit BCD up/down counter fed by toggle-encoded plus/minus/clear lines.
// Toggles become pending requests, serviced one per cycle with priority clear > plus > minus.
module plusminus_sched #(
    parameter int MAX  = 99,
    parameter bit WRAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       plus,
    input  logic       minus,
    input  logic       reset,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       upd,
    output logic       ovf,
    output logic       unf,
    output logic       drop,
    output logic       busy
);

    localparam logic [3:0] MAX_T = 4'(MAX / 10);
    localparam logic [3:0] MAX_O = 4'(MAX % 10);

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;
    typedef enum logic [1:0] {G_NONE = 2'd0, G_CLR = 2'd1, G_INC = 2'd2, G_DEC = 2'd3} grant_t;

    // Returns {tens, ones} one step up, caller guarantees the count is below MAX
    function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o);
        if (o == 4'd9) begin
            bcd_inc = {t + 4'd1, 4'd0};
        end else begin
            bcd_inc = {t, o + 4'd1};
        end
    endfunction

    // Returns {tens, ones} one step down, caller guarantees the count is above 0
    function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] o);
        if (o == 4'd0) begin
            bcd_dec = {t - 4'd1, 4'd9};
        end else begin
            bcd_dec = {t, o - 4'd1};
        end
    endfunction

    state_t     state_r;
    grant_t     grant_r;
    logic       p_d_r, m_d_r, r_d_r;
    logic       pp_r, pm_r, pr_r;
    logic [3:0] ones_r, tens_r;
    logic       upd_r, ovf_r, unf_r, drop_r, busy_r;

    logic       ev_p_s, ev_m_s, ev_r_s;
    logic       clr_p_s, clr_m_s, clr_r_s;
    logic       rem_p_s, rem_m_s, rem_r_s;
    logic       at_max_s, at_zero_s;
    logic [3:0] ones_nx_s, tens_nx_s;
    logic [7:0] digits_s;
    logic       upd_nx_s, ovf_nx_s, unf_nx_s, drop_nx_s;
    grant_t     grant_nx_s;
    state_t     state_nx_s;

    assign ev_p_s    = plus ^ p_d_r;
    assign ev_m_s    = minus ^ m_d_r;
    assign ev_r_s    = reset ^ r_d_r;
    assign at_max_s  = (tens_r == MAX_T) && (ones_r == MAX_O);
    assign at_zero_s = (tens_r == 4'd0) && (ones_r == 4'd0);

    // Flags still pending once this edge's service is taken away; new toggles wait a cycle
    assign rem_p_s = pp_r & ~clr_p_s;
    assign rem_m_s = pm_r & ~clr_m_s;
    assign rem_r_s = pr_r & ~clr_r_s;

    assign drop_nx_s = (ev_p_s & rem_p_s) | (ev_m_s & rem_m_s) | (ev_r_s & rem_r_s);

    // Apply the latched grant to the BCD digits and flag which requests it consumes
    always_comb begin
        clr_p_s   = 1'b0;
        clr_m_s   = 1'b0;
        clr_r_s   = 1'b0;
        ones_nx_s = ones_r;
        tens_nx_s = tens_r;
        digits_s  = 8'd0;
        upd_nx_s  = 1'b0;
        ovf_nx_s  = 1'b0;
        unf_nx_s  = 1'b0;
        if (state_r == EXEC) begin
            upd_nx_s = 1'b1;
            case (grant_r)
                G_CLR: begin
                    clr_r_s   = 1'b1;
                    clr_p_s   = 1'b1;
                    clr_m_s   = 1'b1;
                    ones_nx_s = 4'd0;
                    tens_nx_s = 4'd0;
                end
                G_INC: begin
                    clr_p_s = 1'b1;
                    if (at_max_s) begin
                        ovf_nx_s = 1'b1;
                        if (WRAP) begin
                            ones_nx_s = 4'd0;
                            tens_nx_s = 4'd0;
                        end else begin
                            ones_nx_s = ones_r;
                            tens_nx_s = tens_r;
                        end
                    end else begin
                        digits_s  = bcd_inc(tens_r, ones_r);
                        tens_nx_s = digits_s[7:4];
                        ones_nx_s = digits_s[3:0];
                    end
                end
                G_DEC: begin
                    clr_m_s = 1'b1;
                    if (at_zero_s) begin
                        unf_nx_s = 1'b1;
                        if (WRAP) begin
                            ones_nx_s = MAX_O;
                            tens_nx_s = MAX_T;
                        end else begin
                            ones_nx_s = 4'd0;
                            tens_nx_s = 4'd0;
                        end
                    end else begin
                        digits_s  = bcd_dec(tens_r, ones_r);
                        tens_nx_s = digits_s[7:4];
                        ones_nx_s = digits_s[3:0];
                    end
                end
                default: begin
                    upd_nx_s = 1'b0;
                end
            endcase
        end else begin
            upd_nx_s = 1'b0;
        end
    end

    // Pick the next grant by fixed priority from what remains pending
    always_comb begin
        grant_nx_s = G_NONE;
        state_nx_s = IDLE;
        if (rem_r_s) begin
            grant_nx_s = G_CLR;
            state_nx_s = EXEC;
        end else if (rem_p_s) begin
            grant_nx_s = G_INC;
            state_nx_s = EXEC;
        end else if (rem_m_s) begin
            grant_nx_s = G_DEC;
            state_nx_s = EXEC;
        end else begin
            grant_nx_s = G_NONE;
            state_nx_s = IDLE;
        end
    end

    // All state and registered outputs; a new toggle on a serviced edge re-arms its flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            grant_r <= G_NONE;
            p_d_r   <= 1'b0;
            m_d_r   <= 1'b0;
            r_d_r   <= 1'b0;
            pp_r    <= 1'b0;
            pm_r    <= 1'b0;
            pr_r    <= 1'b0;
            ones_r  <= 4'd0;
            tens_r  <= 4'd0;
            upd_r   <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
            drop_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            grant_r <= grant_nx_s;
            p_d_r   <= plus;
            m_d_r   <= minus;
            r_d_r   <= reset;
            pp_r    <= ev_p_s | rem_p_s;
            pm_r    <= ev_m_s | rem_m_s;
            pr_r    <= ev_r_s | rem_r_s;
            ones_r  <= ones_nx_s;
            tens_r  <= tens_nx_s;
            upd_r   <= upd_nx_s;
            ovf_r   <= ovf_nx_s;
            unf_r   <= unf_nx_s;
            drop_r  <= drop_nx_s;
            busy_r  <= pp_r | pm_r | pr_r;
        end
    end

    assign ones = ones_r;
    assign tens = tens_r;
    assign upd  = upd_r;
    assign ovf  = ovf_r;
    assign unf  = unf_r;
    assign drop = drop_r;
    assign busy = busy_r;

endmodule
